// File: rtl/codec_cfg_seq.sv
// rtl/codec_cfg_seq.sv - WM8731 configuration sequencer over a shared I2C engine
module codec_cfg_seq #(
  parameter logic [7:0] DEV_ADDR  = 8'h34,
  parameter int         GAP_CYC   = 16,
  parameter int         MAX_RETRY = 3,
  parameter logic [6:0] VOL_INIT  = 7'h79,
  parameter logic [6:0] VOL_MIN   = 7'h30,
  parameter logic [6:0] VOL_MAX   = 7'h7F,
  parameter int         TIMEOUT   = 1024
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        END,
  input  logic        ACK,
  input  logic        VOL_UP,
  input  logic        VOL_DN,
  input  logic        REINIT,
  output logic [23:0] I2C_DATA,
  output logic        GO,
  output logic        CFG_DONE,
  output logic        BUSY,
  output logic        ERR,
  output logic [6:0]  VOL
);

  localparam int CNT_TOP = (GAP_CYC > TIMEOUT) ? GAP_CYC : TIMEOUT;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam int RW      = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [3:0] LAST_IDX = 4'd10;
  localparam logic [3:0] VOL_L_IDX = 4'd3;
  localparam logic [3:0] VOL_R_IDX = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_CHECK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          vmode_q, vmode_d;
  logic          go_q, go_d;
  logic [23:0]   data_q, data_d;
  logic          cfg_done_q, cfg_done_d;
  logic          err_q, err_d;
  logic          nack_q, nack_d;
  logic [6:0]    vol_q, vol_d;
  logic          reinit_pend_q, reinit_pend_d;
  logic          vol_pend_q, vol_pend_d;
  logic          vol_chg;

  // {reg[6:0], data[8:0]} for each init table entry; volume entries use the live level
  function automatic logic [15:0] tbl_entry(input logic [3:0] i, input logic [6:0] v);
    logic [15:0] e;
    case (i)
      4'd0:    e = {7'd15, 9'h000};
      4'd1:    e = {7'd0,  9'h017};
      4'd2:    e = {7'd1,  9'h017};
      4'd3:    e = {7'd2,  2'b00, v};
      4'd4:    e = {7'd3,  2'b00, v};
      4'd5:    e = {7'd4,  9'h012};
      4'd6:    e = {7'd5,  9'h000};
      4'd7:    e = {7'd6,  9'h000};
      4'd8:    e = {7'd7,  9'h042};
      4'd9:    e = {7'd8,  9'h000};
      default: e = {7'd9,  9'h001};
    endcase
    return e;
  endfunction

  // Next-state, request bookkeeping and output register values
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    retry_d       = retry_q;
    vmode_d       = vmode_q;
    go_d          = go_q;
    data_d        = data_q;
    cfg_done_d    = cfg_done_q;
    err_d         = err_q;
    nack_d        = nack_q;
    vol_d         = vol_q;
    vol_chg       = 1'b0;
    reinit_pend_d = reinit_pend_q | REINIT;
    vol_pend_d    = vol_pend_q;

    if (VOL_UP && !VOL_DN && (vol_q < VOL_MAX)) begin
      vol_d   = vol_q + 7'd1;
      vol_chg = 1'b1;
    end else if (VOL_DN && !VOL_UP && (vol_q > VOL_MIN)) begin
      vol_d   = vol_q - 7'd1;
      vol_chg = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        go_d = 1'b0;
        if (reinit_pend_q) begin
          reinit_pend_d = REINIT;
          cfg_done_d    = 1'b0;
          vmode_d       = 1'b0;
          idx_d         = 4'd0;
          retry_d       = '0;
          cnt_d         = '0;
          state_d       = S_GAP;
        end else if (vol_pend_q) begin
          vmode_d = 1'b1;
          idx_d   = VOL_L_IDX;
          retry_d = '0;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        data_d  = {DEV_ADDR, tbl_entry(idx_q, vol_q)};
        go_d    = 1'b1;
        cnt_d   = '0;
        nack_d  = 1'b0;
        state_d = S_WAIT_LO;
        // Volume requests that landed before this point are carried by this pass
        if (vmode_q && (idx_q == VOL_L_IDX)) vol_pend_d = 1'b0;
      end
      S_WAIT_LO: begin
        if (!END) begin
          cnt_d   = '0;
          state_d = S_WAIT_HI;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          nack_d  = 1'b1;
          go_d    = 1'b0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (END) begin
          nack_d  = ACK;
          go_d    = 1'b0;
          state_d = S_CHECK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          nack_d  = 1'b1;
          go_d    = 1'b0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (nack_q && (retry_q < RW'(MAX_RETRY))) begin
          retry_d = retry_q + 1'b1;
          state_d = S_GAP;
        end else begin
          if (nack_q) err_d = 1'b1;
          retry_d = '0;
          if (reinit_pend_q || REINIT) begin
            state_d = S_IDLE;
          end else if (!vmode_q) begin
            if (idx_q == LAST_IDX) begin
              cfg_done_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = S_GAP;
            end
          end else if (idx_q == VOL_L_IDX) begin
            idx_d   = VOL_R_IDX;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        go_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (vol_chg) vol_pend_d = 1'b1;
  end

  // State and datapath registers; reset drops GO immediately and restarts the table
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= S_GAP;
      cnt_q         <= '0;
      idx_q         <= 4'd0;
      retry_q       <= '0;
      vmode_q       <= 1'b0;
      go_q          <= 1'b0;
      data_q        <= 24'h0;
      cfg_done_q    <= 1'b0;
      err_q         <= 1'b0;
      nack_q        <= 1'b0;
      vol_q         <= VOL_INIT;
      reinit_pend_q <= 1'b0;
      vol_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      retry_q       <= retry_d;
      vmode_q       <= vmode_d;
      go_q          <= go_d;
      data_q        <= data_d;
      cfg_done_q    <= cfg_done_d;
      err_q         <= err_d;
      nack_q        <= nack_d;
      vol_q         <= vol_d;
      reinit_pend_q <= reinit_pend_d;
      vol_pend_q    <= vol_pend_d;
    end
  end

  assign I2C_DATA = data_q;
  assign GO       = go_q;
  assign CFG_DONE = cfg_done_q;
  assign ERR      = err_q;
  assign VOL      = vol_q;
  assign BUSY     = (state_q != S_IDLE);

endmodule
